clint: RTL and testbench

CLINT -- requirements
Module: clint

---
 rtl/clint_if.sv | 22 ++
 rtl/clint.sv | 114 +++++++++++
 tb/tb_clint.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/clint_if.sv
// Request/response bus between a core-side master and the CLINT register block.
// One request outstanding; the response is a single-cycle pulse.
interface clint_if;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_strobe;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_strobe, req_wdata,
    input  resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_strobe, req_wdata,
    output resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and a prescaled 64-bit mtime.
// Access at the sampling edge, response one cycle later; requests ignored while responding.
module clint #(
  parameter int          TICK_DIV      = 1,
  parameter logic [15:0] BASE_MSIP     = 16'h0000,
  parameter logic [15:0] BASE_MTIMECMP = 16'h4000,
  parameter logic [15:0] BASE_MTIME    = 16'hBFF8
) (
  input  logic   clk,
  input  logic   reset,
  clint_if.slave bus,
  output logic   trint,
  output logic   swint
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  logic        msip;
  logic [63:0] mtimecmp;
  logic [63:0] mtime;
  logic [15:0] presc;

  logic        tick;
  logic        accept;
  logic        aligned;
  logic        hit_msip;
  logic        hit_cmp;
  logic        hit_time;
  logic        hit_any;
  logic        wr_en;
  logic [63:0] mtime_inc;
  logic [63:0] mtime_nxt;
  logic [63:0] mtimecmp_nxt;
  logic        msip_nxt;
  logic [63:0] rd_val;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strobe);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strobe[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign tick      = (presc == PRESC_MAX);
  assign accept    = (state == IDLE) && bus.req_valid;
  assign aligned   = (bus.req_addr[2:0] == 3'b000);
  assign hit_msip  = aligned && (bus.req_addr == BASE_MSIP);
  assign hit_cmp   = aligned && (bus.req_addr == BASE_MTIMECMP);
  assign hit_time  = aligned && (bus.req_addr == BASE_MTIME);
  assign hit_any   = hit_msip || hit_cmp || hit_time;
  assign wr_en     = accept && bus.req_write;
  assign mtime_inc = mtime + 64'(tick);

  // Strobed bytes of a same-edge mtime write override the tick; the rest keep the increment.
  always_comb begin
    mtime_nxt    = mtime_inc;
    mtimecmp_nxt = mtimecmp;
    msip_nxt     = msip;
    if (wr_en && hit_time) mtime_nxt    = merge_bytes(mtime_inc, bus.req_wdata, bus.req_strobe);
    if (wr_en && hit_cmp)  mtimecmp_nxt = merge_bytes(mtimecmp, bus.req_wdata, bus.req_strobe);
    if (wr_en && hit_msip && bus.req_strobe[0]) msip_nxt = bus.req_wdata[0];
  end

  always_comb begin
    rd_val = 64'd0;
    if (hit_msip)      rd_val = {63'd0, msip};
    else if (hit_cmp)  rd_val = mtimecmp;
    else if (hit_time) rd_val = mtime;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      msip           <= 1'b0;
      mtimecmp       <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime          <= 64'd0;
      presc          <= 16'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 64'd0;
      bus.resp_err   <= 1'b0;
    end else begin
      presc          <= tick ? 16'd0 : presc + 16'd1;
      mtime          <= mtime_nxt;
      mtimecmp       <= mtimecmp_nxt;
      msip           <= msip_nxt;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 64'd0;
      bus.resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= !hit_any;
            bus.resp_rdata <= bus.req_write ? 64'd0 : rd_val;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign trint = (mtime >= mtimecmp);
  assign swint = msip;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: one instance at TICK_DIV=1, one at TICK_DIV=4, shared clock and reset.
module tb_clint;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_cnt;
  int   last_snap;

  clint_if bus1();
  clint_if bus4();
  logic trint1, swint1, trint4, swint4;

  clint u_clint1 (.clk(clk), .reset(reset), .bus(bus1.slave), .trint(trint1), .swint(swint1));
  clint #(.TICK_DIV(4)) u_clint4 (.clk(clk), .reset(reset), .bus(bus4.slave), .trint(trint4), .swint(swint4));

  always #5 clk = ~clk;

  // Edges seen with reset released; used to predict mtime.
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic acc(input bit sel, input logic wr, input logic [15:0] addr,
                     input logic [7:0] strb, input logic [63:0] wd,
                     output logic [63:0] rd, output logic er);
    @(negedge clk);
    if (!sel) begin
      bus1.req_valid = 1'b1; bus1.req_write = wr; bus1.req_addr = addr;
      bus1.req_strobe = strb; bus1.req_wdata = wd;
    end else begin
      bus4.req_valid = 1'b1; bus4.req_write = wr; bus4.req_addr = addr;
      bus4.req_strobe = strb; bus4.req_wdata = wd;
    end
    @(posedge clk);
    #1;
    last_snap = edge_cnt;
    bus1.req_valid = 1'b0;
    bus4.req_valid = 1'b0;
    chk("resp_valid_pulse", sel ? bus4.resp_valid : bus1.resp_valid, 1'b1);
    rd = sel ? bus4.resp_rdata : bus1.resp_rdata;
    er = sel ? bus4.resp_err : bus1.resp_err;
    @(posedge clk);
    #1;
    chk("resp_valid_drop", sel ? bus4.resp_valid : bus1.resp_valid, 1'b0);
    chk("resp_rdata_idle", sel ? bus4.resp_rdata : bus1.resp_rdata, 64'd0);
  endtask

  // Leaves the bench so that the next acc() samples on a TICK_DIV=4 tick edge.
  task automatic align_tick();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (((edge_cnt + 1) % 4 != 0) && n < 8);
    chk("align_tick", 64'((edge_cnt + 1) % 4), 64'd0);
  endtask

  logic [63:0] rd;
  logic        er;
  logic [63:0] m;
  logic [63:0] v;

  initial begin
    bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = 0; bus1.req_strobe = 0; bus1.req_wdata = 0;
    bus4.req_valid = 0; bus4.req_write = 0; bus4.req_addr = 0; bus4.req_strobe = 0; bus4.req_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", bus1.resp_valid, 1'b0);
    chk("rst_resp_rdata", bus1.resp_rdata, 64'd0);
    chk("rst_resp_err", bus1.resp_err, 1'b0);
    chk("rst_swint", swint1, 1'b0);
    chk("rst_trint", trint1, 1'b0);
    chk("rst_trint4", trint4, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // mtime read after release returns the number of earlier counting edges
    acc(0, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    chk("mtime_after_reset", rd, 64'(last_snap - 1));
    chk("mtime_read_err", er, 1'b0);
    acc(0, 0, 16'h4000, 8'h00, 64'd0, rd, er);
    chk("mtimecmp_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    acc(0, 0, 16'h0000, 8'h00, 64'd0, rd, er);
    chk("msip_reset", rd, 64'd0);

    // mtime=4 then mtimecmp=20 sampled while mtime=5
    acc(0, 1, 16'hBFF8, 8'hFF, 64'd4, rd, er);
    chk("write_rdata_zero", rd, 64'd0);
    acc(0, 1, 16'h4000, 8'hFF, 64'd20, rd, er);
    chk("cmp_write_err", er, 1'b0);
    m = 64'd7;
    for (int k = 0; k < 16; k++) begin
      chk("trint_level", trint1, (m >= 64'd20) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
      m = m + 64'd1;
    end
    chk("trint_holds", trint1, 1'b1);
    acc(0, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    chk("mtime_track", rd, m);

    // msip / swint
    acc(0, 1, 16'h0000, 8'h01, 64'd1, rd, er);
    chk("swint_set", swint1, 1'b1);
    acc(0, 0, 16'h0000, 8'h00, 64'd0, rd, er);
    chk("msip_read", rd, 64'd1);
    acc(0, 1, 16'h0000, 8'h00, 64'd0, rd, er);
    chk("swint_nostrobe", swint1, 1'b1);
    acc(0, 1, 16'h0000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, rd, er);
    chk("swint_clear_bit0", swint1, 1'b0);
    acc(0, 1, 16'h0000, 8'h00, 64'd1, rd, er);
    chk("swint_nostrobe0", swint1, 1'b0);

    // decode errors
    acc(0, 0, 16'h0004, 8'h00, 64'd0, rd, er);
    chk("err_0004", er, 1'b1);
    chk("err_0004_rdata", rd, 64'd0);
    acc(0, 0, 16'h1000, 8'h00, 64'd0, rd, er);
    chk("err_1000", er, 1'b1);
    chk("err_1000_rdata", rd, 64'd0);
    acc(0, 1, 16'h4004, 8'hFF, 64'd0, rd, er);
    chk("err_4004", er, 1'b1);
    acc(0, 1, 16'h0008, 8'hFF, 64'd1, rd, er);
    chk("err_0008", er, 1'b1);
    chk("err_no_msip", swint1, 1'b0);
    acc(0, 0, 16'h4000, 8'h00, 64'd0, rd, er);
    chk("cmp_unchanged", rd, 64'd20);

    // TICK_DIV=4 rate and phase
    align_tick();
    acc(1, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    v = rd;
    acc(1, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    chk("div4_tick", rd, v + 64'd1);
    acc(1, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    chk("div4_hold", rd, v + 64'd1);
    acc(1, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    chk("div4_next", rd, v + 64'd2);

    // wrap at the next tick after a full write on a tick edge
    align_tick();
    acc(1, 1, 16'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, er);
    acc(1, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    chk("wrap_pre1", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    acc(1, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    chk("wrap_pre2", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    acc(1, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    chk("wrap_zero", rd, 64'd0);

    // partial write on a tick edge: byte 0 from the write, upper bytes incremented
    align_tick();
    acc(1, 1, 16'hBFF8, 8'hFF, 64'h1FF, rd, er);
    align_tick();
    acc(1, 1, 16'hBFF8, 8'h01, 64'hAA, rd, er);
    acc(1, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    chk("tick_merge", rd, 64'h2AA);

    // reset while a response is pending
    acc(0, 1, 16'h0000, 8'h01, 64'd1, rd, er);
    chk("swint_pre_reset", swint1, 1'b1);
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 16'hBFF8;
    @(posedge clk);
    #1;
    chk("resp_before_reset", bus1.resp_valid, 1'b1);
    reset = 1'b0;
    #1;
    bus1.req_valid = 1'b0;
    chk("reset_drops_resp", bus1.resp_valid, 1'b0);
    chk("reset_rdata", bus1.resp_rdata, 64'd0);
    chk("reset_swint", swint1, 1'b0);
    chk("reset_trint", trint1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("no_resp_after_reset", bus1.resp_valid, 1'b0);
    end
    acc(0, 0, 16'hBFF8, 8'h00, 64'd0, rd, er);
    chk("mtime_restart", rd, 64'(last_snap - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
